rnd_num_arbiter: RTL and testbench



---
 rtl/tb_pkg.sv | 10 +
 rtl/rnd_num_arbiter_rr_pick.sv | 31 +++
 rtl/rnd_num_arbiter.sv | 127 ++++++++++++
 tb/tb_rnd_num_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb_pkg.sv
// rtl/tb_pkg.sv - shared testbench-infrastructure types for the random-number arbiter
package tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } rnd_arb_state_e;

endpackage

// File: rtl/rnd_num_arbiter_rr_pick.sv
// rtl/rnd_num_arbiter_rr_pick.sv - first set request bit at or above ptr, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'(wrap(int'(ptr) + i));
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rnd_num_arbiter.sv
// rtl/rnd_num_arbiter.sv - round-robin sharing of one random-number source with per-fetch timeout
module rnd_num_arbiter
    import tb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [WIDTH-1:0]           rsp_data_o,
    output logic                       rsp_err_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic                       rnd_num_req_o,
    input  logic                       rnd_num_valid_i,
    input  logic [WIDTH-1:0]           rnd_num_i
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    rnd_arb_state_e     state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               fetch_q, fetch_d;
    logic [NUM_REQ-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;

    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] owner_onehot;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        fetch_d = fetch_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    fetch_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A valid in the final counted cycle still beats the timeout
                if (rnd_num_valid_i) begin
                    data_d  = rnd_num_i;
                    err_d   = 1'b0;
                    fetch_d = 1'b0;
                    valid_d = owner_onehot;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    fetch_d = 1'b0;
                    valid_d = owner_onehot;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    valid_d = '0;
                    ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            fetch_q <= 1'b0;
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            fetch_q <= fetch_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o   = valid_q;
    assign rsp_data_o    = data_q;
    assign rsp_err_o     = err_q;
    assign owner_o       = owner_q;
    assign busy_o        = (state_q != IDLE);
    assign rnd_num_req_o = fetch_q;

endmodule

// File: tb/tb_rnd_num_arbiter.sv
// tb/tb_rnd_num_arbiter.sv - scoreboarded random and directed bench for rnd_num_arbiter
module tb_rnd_num_arbiter;

    localparam int TMO = 8;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;

    logic [3:0]  req_i = '0, rsp_valid_o, rsp_ready_i = '0;
    logic [31:0] rsp_data_o, rnd_num_i = '0;
    logic        rsp_err_o, busy_o, rnd_num_req_o, rnd_num_valid_i = 1'b0;
    logic [1:0]  owner_o;

    logic [2:0]  req3 = '0, rv3, rr3 = '0;
    logic [31:0] data3, din3 = '0;
    logic        err3, busy3, fq3, vin3 = 1'b0;
    logic [1:0]  own3;

    int   n_vec = 0;
    int   n_err = 0;
    int   ptr_m = 0;
    exp_t exp_q[$];
    exp_t me;

    always #5 clk = ~clk;

    rnd_num_arbiter #(.NUM_REQ(4), .WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .owner_o(owner_o), .busy_o(busy_o), .rnd_num_req_o(rnd_num_req_o),
        .rnd_num_valid_i(rnd_num_valid_i), .rnd_num_i(rnd_num_i)
    );

    rnd_num_arbiter #(.NUM_REQ(3), .WIDTH(32), .TIMEOUT(4)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req3), .rsp_valid_o(rv3),
        .rsp_ready_i(rr3), .rsp_data_o(data3), .rsp_err_o(err3),
        .owner_o(own3), .busy_o(busy3), .rnd_num_req_o(fq3),
        .rnd_num_valid_i(vin3), .rnd_num_i(din3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] rq, input int p);
        for (int i = 0; i < 4; i++) begin
            int t;
            t = (p + i) % 4;
            if (rq[t[1:0]]) return t;
        end
        return 0;
    endfunction

    // Scoreboard monitor: every presented response must match the head of the queue.
    always @(negedge clk) begin
        if (rst_ni && rsp_valid_o != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
            end else begin
                me = exp_q[0];
                chk("rsp", 64'({rsp_valid_o, rsp_data_o, rsp_err_o, owner_o, rnd_num_req_o}),
                    64'({4'(1 << me.owner), me.data, me.err, 2'(me.owner), 1'b0}));
                if ((rsp_valid_o & rsp_ready_i) != '0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_txn(input logic [3:0] rq, input bit to, input int k, input logic [31:0] d,
                          input int bp, input bit stray, input bit keep);
        int   own;
        int   cyc;
        int   hi;
        exp_t e;
        req_i = rq;
        cyc = 0;
        while (!rnd_num_req_o && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("fetch_start", 64'(rnd_num_req_o), 64'd1);
        if (!rnd_num_req_o) return;
        own = pick(rq, ptr_m);
        if (!to) begin
            e = '{own, d, 1'b0};
            exp_q.push_back(e);
            repeat (k - 1) begin @(posedge clk); #1; end
            rnd_num_valid_i = 1'b1;
            rnd_num_i = d;
            @(posedge clk); #1;
            rnd_num_valid_i = 1'b0;
            rnd_num_i = $urandom;
        end else begin
            e = '{own, 32'h0, 1'b1};
            exp_q.push_back(e);
            hi = 1;
            do begin
                @(posedge clk); #1;
                if (rnd_num_req_o) hi++;
            end while (rnd_num_req_o && hi < TMO + 4);
            chk("timeout_len", 64'(hi), 64'(TMO));
        end
        cyc = 0;
        while (rsp_valid_o == '0 && cyc < 4) begin
            @(posedge clk); #1; cyc++;
        end
        chk("rsp_present", 64'(rsp_valid_o != '0), 64'd1);
        if (rsp_valid_o == '0) begin
            exp_q.delete();
            return;
        end
        for (int c = 0; c < bp; c++) begin
            rsp_ready_i = 4'($urandom) & ~(4'b1 << own);
            if (stray) begin
                rnd_num_valid_i = 1'($urandom_range(0, 1));
                rnd_num_i = $urandom;
            end
            @(posedge clk); #1;
        end
        rnd_num_valid_i = 1'b0;
        rsp_ready_i = 4'($urandom) | (4'b1 << own);
        @(posedge clk); #1;
        rsp_ready_i = '0;
        ptr_m = (own + 1) % 4;
        req_i = keep ? rq : (rq & ~(4'b1 << own));
        chk("idle_after_hs", 64'({busy_o, rsp_valid_o}), 64'd0);
    endtask

    initial begin
        logic [3:0]  pend;
        logic [31:0] d3;
        int          cyc;

        #12;
        chk("reset4", 64'({rnd_num_req_o, rsp_valid_o, rsp_data_o, rsp_err_o, owner_o, busy_o}), 64'd0);
        chk("reset3", 64'({fq3, rv3, data3, err3, own3, busy3}), 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // All four requesting continuously: expect owners 0,1,2,3,0
        for (int i = 0; i < 5; i++)
            do_txn(4'b1111, 1'b0, $urandom_range(1, TMO), $urandom, 0, 1'b0, 1'b1);

        do_txn(4'b0010, 1'b0, 1, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        do_txn(4'b0111, 1'b0, 2, $urandom, 0, 1'b0, 1'b0);
        do_txn(4'b0001, 1'b1, 0, 32'h0, 1, 1'b0, 1'b0);
        do_txn(4'b1100, 1'b0, TMO, $urandom, 0, 1'b0, 1'b0);
        do_txn(4'b1111, 1'b0, 3, $urandom, 10, 1'b1, 1'b0);

        pend = 4'($urandom_range(1, 15));
        for (int i = 0; i < 40; i++) begin
            do_txn(pend, ($urandom_range(0, 7) == 0), $urandom_range(1, TMO), $urandom,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
            pend = req_i | 4'($urandom_range(0, 15));
            if (pend == '0) pend = 4'b0100;
        end

        // Reset mid-FETCH with ptr left at 2
        do_txn(4'b0010, 1'b0, 1, $urandom, 0, 1'b0, 1'b0);
        req_i = 4'b0100;
        cyc = 0;
        while (!rnd_num_req_o && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("pre_rst_fetch", 64'({rnd_num_req_o, owner_o}), 64'({1'b1, 2'd2}));
        rst_ni = 1'b0;
        #2;
        chk("rst_async", 64'({rnd_num_req_o, rsp_valid_o, rsp_data_o, rsp_err_o, owner_o, busy_o}), 64'd0);
        req_i = '0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        ptr_m = 0;
        exp_q.delete();
        do_txn(4'b1010, 1'b0, 1, $urandom, 0, 1'b0, 1'b0);
        do_txn(4'b1000, 1'b0, 2, $urandom, 0, 1'b0, 1'b0);

        // NUM_REQ=3 wrap: owner 2 completes, next 3'b111 goes to 0
        d3 = $urandom;
        req3 = 3'b100;
        cyc = 0;
        while (!fq3 && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("n3_fetch", 64'({fq3, own3}), 64'({1'b1, 2'd2}));
        vin3 = 1'b1;
        din3 = d3;
        @(posedge clk); #1;
        vin3 = 1'b0;
        chk("n3_rsp", 64'({rv3, data3, err3}), 64'({3'b100, d3, 1'b0}));
        rr3 = 3'b100;
        @(posedge clk); #1;
        rr3 = '0;
        req3 = 3'b111;
        cyc = 0;
        while (!fq3 && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("n3_wrap", 64'({fq3, own3}), 64'({1'b1, 2'd0}));
        req3 = 3'b110;
        cyc = 0;
        while (rv3 == '0 && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("n3_timeout", 64'({rv3, data3, err3}), 64'({3'b001, 32'h0, 1'b1}));
        rr3 = 3'b001;
        @(posedge clk); #1;
        rr3 = '0;
        req3 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
